// File: rtl/wb_register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_register_file_pkg
//  Brief    : Shared MIPS write-back definitions: default widths, the
//             hard-wired zero register and the MEM/WB WB-bundle bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package wb_register_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    // $0 is hard-wired to zero in the MIPS register file
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit positions inside the MEM/WB WB control bundle
    localparam int WB_MEMTOREG = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_BUNDLE_W = 2;

endpackage : wb_register_file_pkg
`default_nettype wire

// File: rtl/wb_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_register_file_if
//  Brief    : MEM/WB -> register-file bus: write-back inputs, ID-stage and
//             debug read addresses, read data, forwarded write data and the
//             retired-write counter. The pipeline side is the master.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              MemtoReg;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALUresult;
    logic [ADDR_W-1:0] DirWriteReg;
    logic [ADDR_W-1:0] DirRead1;
    logic [ADDR_W-1:0] DirRead2;
    logic [ADDR_W-1:0] DirDebug;
    logic [DATA_W-1:0] O_Read1;
    logic [DATA_W-1:0] O_Read2;
    logic [DATA_W-1:0] O_Debug;
    logic [DATA_W-1:0] O_WriteData;
    logic [CNT_W-1:0]  O_WriteCount;

    modport master (
        output MemtoReg, RegWrite, ReadData, ALUresult,
               DirWriteReg, DirRead1, DirRead2, DirDebug,
        input  O_Read1, O_Read2, O_Debug, O_WriteData, O_WriteCount
    );

    modport slave (
        input  MemtoReg, RegWrite, ReadData, ALUresult,
               DirWriteReg, DirRead1, DirRead2, DirDebug,
        output O_Read1, O_Read2, O_Debug, O_WriteData, O_WriteCount
    );

endinterface : wb_register_file_if
`default_nettype wire

// File: rtl/wb_register_file_wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux
//  Brief    : Write-back select: load data when MemtoReg is set, otherwise the
//             ALU result. Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  wire logic              mem_to_reg,
    input  wire logic [DATA_W-1:0] read_data,
    input  wire logic [DATA_W-1:0] alu_result,
    output logic      [DATA_W-1:0] write_data
);

    // 2:1 select of the value to be committed
    always_comb begin
        write_data = alu_result;
        if (mem_to_reg) begin
            write_data = read_data;
        end
    end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : wb_register_file
//  Brief    : MIPS write-back stage and 2**ADDR_W x DATA_W register file with
//             two asynchronous ID-stage read ports, a debug read port and a
//             retired-write counter.
//  Config   : WB_BYPASS_EN - when defined, rs/rt reads of the register being
//             written this cycle return the write-back value combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module wb_register_file
    import wb_register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_register_file_if.slave bus
);

    localparam int                 NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [CNT_W-1:0]       r_write_count;
    logic [WB_BUNDLE_W-1:0] w_wb;
    logic [DATA_W-1:0]      w_write_data;
    logic                   w_commit;
    logic [DATA_W-1:0]      w_read1;
    logic [DATA_W-1:0]      w_read2;

    // Rebuild the MEM/WB WB bundle so control bits are taken by position
    always_comb begin
        w_wb               = '0;
        w_wb[WB_MEMTOREG]  = bus.MemtoReg;
        w_wb[WB_REGWRITE]  = bus.RegWrite;
    end

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg (w_wb[WB_MEMTOREG]),
        .read_data  (bus.ReadData),
        .alu_result (bus.ALUresult),
        .write_data (w_write_data)
    );

    // A write retires only when enabled and not aimed at $0
    assign w_commit = w_wb[WB_REGWRITE] && (bus.DirWriteReg != ZERO_ADDR);

    // Register array: cleared by reset, one write per edge; $0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[bus.DirWriteReg] <= w_write_data;
        end
    end

    // Retired-write counter, wraps naturally at 2**CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_count <= '0;
        end else if (w_commit) begin
            r_write_count <= r_write_count + CNT_W'(1);
        end
    end

    // rs/rt read ports; the optional bypass is suppressed during reset so
    // every read port shows zero while rst is asserted
    always_comb begin
        w_read1 = r_regs[bus.DirRead1];
        w_read2 = r_regs[bus.DirRead2];
`ifdef WB_BYPASS_EN
        if (!rst && w_commit && (bus.DirRead1 == bus.DirWriteReg)) begin
            w_read1 = w_write_data;
        end
        if (!rst && w_commit && (bus.DirRead2 == bus.DirWriteReg)) begin
            w_read2 = w_write_data;
        end
`endif
    end

    assign bus.O_Read1      = w_read1;
    assign bus.O_Read2      = w_read2;
    assign bus.O_Debug      = r_regs[bus.DirDebug];
    assign bus.O_WriteData  = w_write_data;
    assign bus.O_WriteCount = r_write_count;

endmodule : wb_register_file
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_register_file
//  Brief    : Randomised bench for wb_register_file with a scoreboard queue.
//             A second instance with a 4-bit counter exercises wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_register_file;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] dbg;
        logic [31:0] wd;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_register_file_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus  ();
    wb_register_file_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_c4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // The narrow-counter instance sees exactly the same traffic
    always_comb begin
        bus4.MemtoReg    = bus.MemtoReg;
        bus4.RegWrite    = bus.RegWrite;
        bus4.ReadData    = bus.ReadData;
        bus4.ALUresult   = bus.ALUresult;
        bus4.DirWriteReg = bus.DirWriteReg;
        bus4.DirRead1    = bus.DirRead1;
        bus4.DirRead2    = bus.DirRead2;
        bus4.DirDebug    = bus.DirDebug;
    end

    // Reference model: architectural register contents and retired writes
    logic [31:0] model_mem [32];
    longint      model_writes;

    exp_t sb [$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show before the edge
    task automatic apply(input logic r, input logic rw, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] ad);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.RegWrite    = rw;
        bus.MemtoReg    = m2r;
        bus.ReadData    = rd;
        bus.ALUresult   = alu;
        bus.DirWriteReg = wr;
        bus.DirRead1    = a1;
        bus.DirRead2    = a2;
        bus.DirDebug    = ad;
        if (r) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
            model_writes = 0;
        end
        e.wd  = m2r ? rd : alu;
        e.r1  = model_read(a1);
        e.r2  = model_read(a2);
        e.dbg = model_read(ad);
`ifdef WB_BYPASS_EN
        if (!r && rw && wr != 5'd0 && a1 == wr) e.r1 = e.wd;
        if (!r && rw && wr != 5'd0 && a2 == wr) e.r2 = e.wd;
`endif
        e.cnt  = 32'(model_writes % 64'h1_0000_0000);
        e.cnt4 = 4'(model_writes % 16);
        sb.push_back(e);
        if (!r && rw && wr != 5'd0) begin
            model_mem[wr] = e.wd;
            model_writes++;
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare against the queued response
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("read1",      bus.O_Read1,              mon_e.r1);
                check("read2",      bus.O_Read2,              mon_e.r2);
                check("debug",      bus.O_Debug,              mon_e.dbg);
                check("write_data", bus.O_WriteData,          mon_e.wd);
                check("count",      bus.O_WriteCount,         mon_e.cnt);
                check("count4",     {28'd0, bus4.O_WriteCount}, {28'd0, mon_e.cnt4});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.ReadData    = '0;
        bus.ALUresult   = '0;
        bus.DirWriteReg = '0;
        bus.DirRead1    = '0;
        bus.DirRead2    = '0;
        bus.DirDebug    = '0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        model_writes = 0;

        // Reset state, with a write attempted while reset is held
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'h5555_5555, 5'd4, 5'd4, 5'd0, 5'd4);
        apply(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,         5'd0, 5'd4, 5'd4, 5'd4);

        // ALU write to $8, then read it back on rs
        apply(1'b0, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0000_1234, 5'd8, 5'd8, 5'd1, 5'd8);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd8, 5'd8);

        // Load write to $31, visible on debug after the edge
        apply(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd31, 5'd31, 5'd31, 5'd31);
        apply(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 5'd31, 5'd31, 5'd31);

        // Write to $0 is dropped and not counted
        apply(1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Same-cycle read of the register being written ($5: 7 -> 9)
        apply(1'b0, 1'b1, 1'b0, 32'd0, 32'd7, 5'd5, 5'd1, 5'd2, 5'd3);
        apply(1'b0, 1'b1, 1'b0, 32'd0, 32'd9, 5'd5, 5'd5, 5'd5, 5'd5);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5, 5'd5);

        // Mid-run reset after writes, with a write in flight
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'h0BAD_0BAD, 5'd8, 5'd8, 5'd31, 5'd5);
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd31, 5'd5);

        // Randomised traffic; the 4-bit counter wraps many times
        for (int n = 0; n < 600; n++) begin
            logic       r, rw, m2r;
            logic [4:0] wr, a1, a2, ad;
            r   = ($urandom_range(0, 79) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            m2r = 1'($urandom);
            wr  = 5'($urandom);
            a1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            a2  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
            ad  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            apply(r, rw, m2r, $urandom, $urandom, wr, a1, a2, ad);
        end
        apply(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wb_register_file
`default_nettype wire
